// File: rtl/traffic_pkg.sv
// traffic_pkg: state encodings and lamp codes shared by the intersection light modules
package traffic_pkg;
  typedef enum logic [2:0] {
    NS_G     = 3'd0,
    NS_Y     = 3'd1,
    ALLRED_A = 3'd2,
    EW_G     = 3'd3,
    EW_Y     = 3'd4,
    ALLRED_B = 3'd5,
    BLINK    = 3'd6
  } state_t;
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;
  localparam logic [2:0] OFF    = 3'b000;
  function automatic logic [2:0] lamp(input state_t s, input state_t g, input state_t y, input logic ph);
    return s == BLINK ? (ph ? RED : OFF) : s == g ? GREEN : s == y ? YELLOW : RED;
  endfunction
endpackage

// File: rtl/phase_timer.sv
// phase_timer: free-running phase counter with synchronous clear and terminal-count flag
module phase_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             done
);
  logic [CNT_W-1:0] r_count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_count <= '0;
    else        r_count <= clr ? '0 : r_count + CNT_W'(1);
  assign count = r_count;
  assign done  = r_count == limit - CNT_W'(1);
endmodule

// File: rtl/intersection_scheduler.sv
// intersection_scheduler: NS/EW signal sequencer with pedestrian early-cut and night blink
module intersection_scheduler
  import traffic_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int T_GREEN      = 800000000,
  parameter int T_MIN_GREEN  = 300000000,
  parameter int T_YELLOW     = 200000000,
  parameter int T_ALLRED     = 100000000,
  parameter int T_BLINK_HALF = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       blink_req,
  input  logic       ped_req_ns,
  input  logic       ped_req_ew,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk_ns,
  output logic       walk_ew,
  output logic [1:0] ped_pend,
  output logic       blink_active
);
  state_t           r_state, w_nxt;
  logic [CNT_W-1:0] w_count, w_limit;
  logic             w_done, w_clr, w_min, w_phase, r_phase;
  logic [1:0]       w_pend, r_pend;
  logic [2:0]       r_ns, r_ew;
  logic             r_wns, r_wew, r_blink;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk(clk), .rst_n(rst_n), .clr(w_clr), .limit(w_limit), .count(w_count), .done(w_done)
  );

  always_comb begin
    w_limit = (r_state == NS_G || r_state == EW_G) ? CNT_W'(T_GREEN) :
              (r_state == NS_Y || r_state == EW_Y) ? CNT_W'(T_YELLOW) :
              r_state == BLINK ? CNT_W'(T_BLINK_HALF) : CNT_W'(T_ALLRED);
    w_min = w_count >= CNT_W'(T_MIN_GREEN - 1);
    case (r_state)
      NS_G:     w_nxt = (w_done || (w_min && (r_pend[1] || ped_req_ew))) ? NS_Y : NS_G;
      NS_Y:     w_nxt = w_done ? ALLRED_B : NS_Y;
      ALLRED_B: w_nxt = w_done ? (blink_req ? BLINK : EW_G) : ALLRED_B;
      EW_G:     w_nxt = (w_done || (w_min && (r_pend[0] || ped_req_ns))) ? EW_Y : EW_G;
      EW_Y:     w_nxt = w_done ? ALLRED_A : EW_Y;
      ALLRED_A: w_nxt = w_done ? (blink_req ? BLINK : NS_G) : ALLRED_A;
      BLINK:    w_nxt = blink_req ? BLINK : ALLRED_A;
      default:  w_nxt = ALLRED_A;
    endcase
    w_clr   = w_nxt != r_state || (r_state == BLINK && w_done);
    w_phase = (r_state == BLINK && w_nxt == BLINK) ? r_phase ^ w_done : 1'b1;
    // a request on the approach already green is dropped; entering a green clears its own request
    w_pend  = (r_pend | {ped_req_ew && r_state != EW_G, ped_req_ns && r_state != NS_G}) &
              ~{w_nxt == EW_G && r_state != EW_G, w_nxt == NS_G && r_state != NS_G};
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= ALLRED_A;
      r_pend  <= '0;
      r_phase <= 1'b1;
      r_ns    <= RED;
      r_ew    <= RED;
      r_wns   <= 1'b0;
      r_wew   <= 1'b0;
      r_blink <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_pend  <= w_pend;
      r_phase <= w_phase;
      r_ns    <= lamp(w_nxt, NS_G, NS_Y, w_phase);
      r_ew    <= lamp(w_nxt, EW_G, EW_Y, w_phase);
      r_wns   <= w_nxt == NS_G;
      r_wew   <= w_nxt == EW_G;
      r_blink <= w_nxt == BLINK;
    end

  assign ns_light     = r_ns;
  assign ew_light     = r_ew;
  assign walk_ns      = r_wns;
  assign walk_ew      = r_wew;
  assign ped_pend     = r_pend;
  assign blink_active = r_blink;
endmodule

// File: tb/tb_intersection_scheduler.sv
// tb_intersection_scheduler: directed checks of light sequencing, ped requests, blink and async reset
module tb_intersection_scheduler;
  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001, O = 3'b000;
  logic clk = 1'b0, rst_n = 1'b0, blink_req = 1'b0, ped_req_ns = 1'b0, ped_req_ew = 1'b0;
  logic [2:0] ns_light, ew_light;
  logic walk_ns, walk_ew, blink_active;
  logic [1:0] ped_pend;
  int n_tests = 0, n_fail = 0;

  intersection_scheduler #(
    .CNT_W(32), .T_GREEN(8), .T_MIN_GREEN(3), .T_YELLOW(2), .T_ALLRED(1), .T_BLINK_HALF(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .blink_req(blink_req), .ped_req_ns(ped_req_ns), .ped_req_ew(ped_req_ew),
    .ns_light(ns_light), .ew_light(ew_light), .walk_ns(walk_ns), .walk_ew(walk_ew),
    .ped_pend(ped_pend), .blink_active(blink_active)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst_n && !blink_active) begin
      n_tests++;
      assert (ns_light === R || ew_light === R) else begin
        n_fail++;
        $error("FAIL safety: ns=%b ew=%b required one of them 100", ns_light, ew_light);
      end
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic [2:0] ns, input logic [2:0] ew,
                     input logic wn, input logic we, input logic bl);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("ns_light", 32'(ns_light), 32'(ns));
      chk("ew_light", 32'(ew_light), 32'(ew));
      chk("walk_ns", 32'(walk_ns), 32'(wn));
      chk("walk_ew", 32'(walk_ew), 32'(we));
      chk("blink_active", 32'(blink_active), 32'(bl));
    end
  endtask

  initial begin
    #12;
    chk("rst_ns", 32'(ns_light), 32'(R));
    chk("rst_ew", 32'(ew_light), 32'(R));
    chk("rst_pend", 32'(ped_pend), 0);
    chk("rst_walk", 32'({walk_ns, walk_ew}), 0);
    chk("rst_blink", 32'(blink_active), 0);
    rst_n = 1'b1;
    // full unloaded cycle
    run(8, G, R, 1, 0, 0);
    run(2, Y, R, 0, 0, 0);
    run(1, R, R, 0, 0, 0);
    run(8, R, G, 0, 1, 0);
    run(2, R, Y, 0, 0, 0);
    run(1, R, R, 0, 0, 0);
    // ew request at NS_G timer 0 cuts green to 3 cycles
    run(1, G, R, 1, 0, 0);
    ped_req_ew = 1'b1;
    run(1, G, R, 1, 0, 0);
    ped_req_ew = 1'b0;
    chk("pend_ew_set", 32'(ped_pend), 32'b10);
    run(1, G, R, 1, 0, 0);
    run(2, Y, R, 0, 0, 0);
    run(1, R, R, 0, 0, 0);
    run(1, R, G, 0, 1, 0);
    chk("pend_ew_clr", 32'(ped_pend), 0);
    run(7, R, G, 0, 1, 0);
    run(2, R, Y, 0, 0, 0);
    run(1, R, R, 0, 0, 0);
    // ns request during NS_G ignored; ew request at timer 6 exits next cycle
    run(1, G, R, 1, 0, 0);
    ped_req_ns = 1'b1;
    run(1, G, R, 1, 0, 0);
    ped_req_ns = 1'b0;
    chk("pend_ns_ignored", 32'(ped_pend), 0);
    run(5, G, R, 1, 0, 0);
    ped_req_ew = 1'b1;
    run(1, Y, R, 0, 0, 0);
    ped_req_ew = 1'b0;
    chk("pend_ew_late", 32'(ped_pend), 32'b10);
    run(1, Y, R, 0, 0, 0);
    run(1, R, R, 0, 0, 0);
    run(1, R, G, 0, 1, 0);
    chk("pend_ew_late_clr", 32'(ped_pend), 0);
    run(7, R, G, 0, 1, 0);
    run(2, R, Y, 0, 0, 0);
    run(1, R, R, 0, 0, 0);
    // blink request mid green waits for the all-red
    run(3, G, R, 1, 0, 0);
    blink_req = 1'b1;
    run(5, G, R, 1, 0, 0);
    run(2, Y, R, 0, 0, 0);
    run(1, R, R, 0, 0, 0);
    run(4, R, R, 0, 0, 1);
    run(4, O, O, 0, 0, 1);
    run(4, R, R, 0, 0, 1);
    // ns request latched in blink, served on resume
    ped_req_ns = 1'b1;
    run(1, O, O, 0, 0, 1);
    ped_req_ns = 1'b0;
    chk("pend_ns_blink", 32'(ped_pend), 32'b01);
    blink_req = 1'b0;
    run(1, R, R, 0, 0, 0);
    chk("pend_ns_allred", 32'(ped_pend), 32'b01);
    run(1, G, R, 1, 0, 0);
    chk("pend_ns_clr", 32'(ped_pend), 0);
    run(7, G, R, 1, 0, 0);
    run(2, Y, R, 0, 0, 0);
    run(1, R, R, 0, 0, 0);
    run(8, R, G, 0, 1, 0);
    run(1, R, Y, 0, 0, 0);
    ped_req_ns = 1'b1;
    run(1, R, Y, 0, 0, 0);
    ped_req_ns = 1'b0;
    chk("pend_before_rst", 32'(ped_pend), 32'b01);
    // asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ns", 32'(ns_light), 32'(R));
    chk("arst_ew", 32'(ew_light), 32'(R));
    chk("arst_pend", 32'(ped_pend), 0);
    chk("arst_walk", 32'({walk_ns, walk_ew}), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
